// File: rtl/apb_to_bus_bridge.sv
// APB4 completer that turns each APB transfer into one simple-bus transaction.
// One transaction outstanding; programmable timeout forces APB completion.
module apb_to_bus_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic                    bus_ena,
  output logic [DATA_WIDTH/8-1:0] bus_wstb,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic                    bus_ready,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_slverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t                  state, state_n;
  logic                    pready_n;
  logic [DATA_WIDTH-1:0]   prdata_n;
  logic                    pslverr_n;
  logic                    bus_ena_n;
  logic [STRB_WIDTH-1:0]   bus_wstb_n;
  logic [ADDR_WIDTH-1:0]   bus_addr_n;
  logic [DATA_WIDTH-1:0]   bus_wdata_n;
  logic [CNT_WIDTH-1:0]    cnt, cnt_n;
  logic                    abandon, abandon_n;
  logic                    done;
  logic [DATA_WIDTH-1:0]   done_rdata;
  logic                    done_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
      bus_ena   <= 1'b0;
      bus_wstb  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cnt       <= '0;
      abandon   <= 1'b0;
    end else begin
      state     <= state_n;
      pready    <= pready_n;
      prdata    <= prdata_n;
      pslverr   <= pslverr_n;
      bus_ena   <= bus_ena_n;
      bus_wstb  <= bus_wstb_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
      cnt       <= cnt_n;
      abandon   <= abandon_n;
    end
  end

  always_comb begin
    state_n     = state;
    pready_n    = pready;
    prdata_n    = prdata;
    pslverr_n   = pslverr;
    bus_ena_n   = bus_ena;
    bus_wstb_n  = bus_wstb;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
    cnt_n       = cnt;
    abandon_n   = abandon;
    done        = 1'b0;
    done_rdata  = '0;
    done_err    = 1'b0;

    case (state)
      IDLE: begin
        abandon_n = 1'b0;
        cnt_n     = '0;
        if (psel && !penable) begin
          bus_addr_n  = paddr;
          bus_wdata_n = pwdata;
          bus_wstb_n  = pwrite ? pstrb : '0;
          if (pwrite && (pstrb == '0)) begin
            pready_n  = 1'b1;
            pslverr_n = 1'b0;
            prdata_n  = '0;
            state_n   = RESP;
          end else begin
            bus_ena_n = 1'b1;
            state_n   = REQ;
          end
        end
      end

      REQ: begin
        if (!psel) begin
          abandon_n = 1'b1;
        end
        // A read is the only way into REQ with all strobes clear, so the
        // captured strobes double as the read/write flag.
        if (bus_ready) begin
          done       = 1'b1;
          done_rdata = (bus_wstb == '0) ? bus_rdata : '0;
          done_err   = bus_slverr;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
          done       = 1'b1;
          done_rdata = '0;
          done_err   = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_n = cnt + 1'b1;
        end

        if (done) begin
          bus_ena_n = 1'b0;
          // After a psel drop the APB side has moved on: complete silently.
          if (abandon_n) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            pready_n  = 1'b1;
            prdata_n  = done_rdata;
            pslverr_n = done_err;
            state_n   = RESP;
          end
        end
      end

      RESP: begin
        pready_n  = 1'b0;
        prdata_n  = '0;
        pslverr_n = 1'b0;
        cnt_n     = '0;
        state_n   = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_to_bus_bridge.sv
// Self-checking bench for apb_to_bus_bridge: directed cases plus randomized
// transfers checked against a cycle-level reference model.
module tb_apb_to_bus_bridge;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        bus_ena;
  logic [3:0]  bus_wstb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_slverr;

  int checks;
  int errors;

  apb_to_bus_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr),
    .bus_ena    (bus_ena),
    .bus_wstb   (bus_wstb),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata),
    .bus_slverr (bus_slverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected APB-visible outcome derived from the transfer rules alone.
  task automatic ref_model(input logic w, input logic [3:0] st, input int unsigned waits,
                           input logic [31:0] rd, input logic se,
                           output int exp_cyc, output logic [31:0] exp_rd,
                           output logic exp_err, output int exp_ena);
    if (w && st == 4'h0) begin
      exp_cyc = 1; exp_rd = '0; exp_err = 1'b0; exp_ena = 0;
    end else if (waits < TO) begin
      exp_cyc = int'(waits) + 2; exp_ena = int'(waits) + 1;
      exp_rd  = w ? 32'h0 : rd;  exp_err = se;
    end else begin
      exp_cyc = int'(TO) + 1; exp_ena = int'(TO);
      exp_rd  = '0; exp_err = 1'b1;
    end
  endtask

  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input int unsigned waits,
                          input logic [31:0] rd, input logic se,
                          output int pr_cyc, output logic [31:0] prd, output logic perr,
                          output int ena_cyc, output logic hold_ok, output logic after_ok);
    int unsigned waited;
    pr_cyc = -1; prd = '0; perr = 1'b0; ena_cyc = 0; hold_ok = 1'b1; waited = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = st;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus_ena && waited == waits) begin
        bus_ready = 1'b1; bus_rdata = rd; bus_slverr = se;
      end else begin
        bus_ready = 1'b0; bus_rdata = $urandom; bus_slverr = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (bus_ena) begin
        ena_cyc++;
        if (bus_addr !== a || bus_wdata !== wd || bus_wstb !== (w ? st : 4'h0)) hold_ok = 1'b0;
      end
      if (pready) begin
        pr_cyc = cyc; prd = prdata; perr = pslverr;
        break;
      end
      if (bus_ena) waited++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; bus_ready = 1'b0;
    @(negedge clk);
    after_ok = (pready === 1'b0 && prdata === 32'h0 && pslverr === 1'b0 && bus_ena === 1'b0);
  endtask

  task automatic run(input string tag, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input int unsigned waits,
                     input logic [31:0] rd, input logic se);
    int pr_cyc, ena_cyc, exp_cyc, exp_ena;
    logic [31:0] prd, exp_rd;
    logic perr, exp_err, hold_ok, after_ok;
    ref_model(w, st, waits, rd, se, exp_cyc, exp_rd, exp_err, exp_ena);
    apb_xfer(w, a, wd, st, waits, rd, se, pr_cyc, prd, perr, ena_cyc, hold_ok, after_ok);
    chk({tag, "_pready_cycle"}, 64'(pr_cyc), 64'(exp_cyc));
    chk({tag, "_prdata"}, 64'(prd), 64'(exp_rd));
    chk({tag, "_pslverr"}, 64'(perr), 64'(exp_err));
    chk({tag, "_bus_ena_cycles"}, 64'(ena_cyc), 64'(exp_ena));
    chk({tag, "_bus_fields_stable"}, 64'(hold_ok), 64'(1));
    chk({tag, "_return_idle"}, 64'(after_ok), 64'(1));
  endtask

  initial begin
    logic        seen;
    logic        w, se;
    logic [3:0]  st;
    int unsigned waits;

    checks = 0; errors = 0;
    clk = 1'b0; rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    bus_ready = 1'b0; bus_rdata = '0; bus_slverr = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pready", 64'(pready), 64'(0));
    chk("reset_prdata", 64'(prdata), 64'(0));
    chk("reset_pslverr", 64'(pslverr), 64'(0));
    chk("reset_bus_ena", 64'(bus_ena), 64'(0));
    chk("reset_bus_fields", {bus_wstb, bus_addr, bus_wdata[27:0]}, 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    run("rd_zero_wait", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
    run("wr_three_wait", 1'b1, 32'h24, 32'h12345678, 4'b0101, 3, 32'h0, 1'b0);
    run("rd_slverr", 1'b0, 32'h30, 32'h0, 4'h0, 1, 32'hFFFFFFFF, 1'b1);
    run("rd_timeout", 1'b0, 32'h44, 32'h0, 4'h0, 100, 32'h0, 1'b0);

    // Late bus_ready after timeout must not reach APB.
    seen = 1'b0;
    @(posedge clk); #1; bus_ready = 1'b1; bus_rdata = 32'hBAD0BAD0;
    repeat (2) begin
      @(negedge clk);
      if (pready !== 1'b0 || bus_ena !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    bus_ready = 1'b0;
    chk("late_ready_ignored", 64'(seen), 64'(0));

    run("wr_null_strobe", 1'b1, 32'h50, 32'hCAFEF00D, 4'h0, 0, 32'h0, 1'b0);

    // Reset in the middle of a bus request.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h60; pstrb = '0; bus_ready = 1'b0;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ena_before", 64'(bus_ena), 64'(1));
    rst = 1'b1; #1;
    chk("mid_rst_ena_dropped", 64'(bus_ena), 64'(0));
    chk("mid_rst_pready", 64'(pready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    run("rd_after_reset", 1'b0, 32'h64, 32'h0, 4'h0, 2, 32'h5A5A1234, 1'b0);

    // psel dropped while the bus request is pending: response is discarded.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h80; pwdata = 32'h11112222; pstrb = 4'hF;
    bus_ready = 1'b0;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0; bus_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready !== 1'b0) seen = 1'b1;
      @(posedge clk); #1; bus_ready = 1'b0;
    end
    chk("abandon_no_pready", 64'(seen), 64'(0));
    chk("abandon_ena_low", 64'(bus_ena), 64'(0));
    run("rd_after_abandon", 1'b0, 32'h84, 32'h0, 4'h0, 0, 32'h0BADCAFE, 1'b0);

    for (int i = 0; i < 20; i++) begin
      w     = 1'($urandom_range(0, 1));
      st    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) st = 4'h0;
      waits = $urandom_range(0, 5);
      se    = 1'($urandom_range(0, 1));
      run($sformatf("rand%0d", i), w, $urandom, $urandom, st, waits, $urandom, se);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_to_bus_bridge.md
Name: apb_to_bus_bridge

Overview:
- APB4 completer that converts each APB transfer into one transaction on the internal simple bus, acting as the bus master (drives bus_ena/bus_wstb/bus_addr/bus_wdata, samples bus_ready/bus_rdata/bus_slverr).
- It is the reverse of the bus-to-APB path. It lets APB-attached test masters or external hosts reach bus-side slaves.
- Exactly one transaction is outstanding at a time. A programmable timeout guarantees APB completion.

Parameters:
- ADDR_WIDTH, 32, width of paddr and bus_addr.
- DATA_WIDTH, 32, width of data; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, maximum cycles bus_ena may stay high without bus_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  APB address.
- pwdata  in  DATA_WIDTH  APB write data.
- pstrb  in  DATA_WIDTH/8  APB write strobes.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data, valid when pready=1.
- pslverr  out  1  error response, valid when pready=1.
- bus_ena  out  1  bus request, held until handshake.
- bus_wstb  out  DATA_WIDTH/8  byte write strobes; all-zero = read.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_wdata  out  DATA_WIDTH  bus write data.
- bus_ready  in  1  bus completion; handshake = bus_ena & bus_ready at a clock edge.
- bus_rdata  in  DATA_WIDTH  bus read data, valid with bus_ready.
- bus_slverr  in  1  bus error, valid with bus_ready.

Behaviour:
- Reset values (async, immediate):
  - FSM=IDLE.
  - pready=0, prdata=0, pslverr=0.
  - bus_ena=0, bus_wstb=0, bus_addr=0, bus_wdata=0.
  - Timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On psel=1 & penable=0 (setup phase), capture the transfer into the bus outputs:
    - bus_addr <= paddr.
    - bus_wdata <= pwdata.
    - bus_wstb <= pwrite ? pstrb : 0.
  - Read, or write with pstrb≠0: bus_ena <= 1, go to REQ.
  - Write with pstrb==0: no bus request. pready <= 1, pslverr <= 0, go to RESP.
  - psel=1 & penable=1 seen in IDLE (no prior setup phase) is ignored.
- REQ:
  - Handshake (bus_ready=1):
    - bus_ena <= 0.
    - prdata <= (read ? bus_rdata : 0).
    - pslverr <= bus_slverr.
    - pready <= 1.
    - Go to RESP.
  - Timeout counter increments each REQ cycle without a handshake. When it reaches TIMEOUT_CYCLES:
    - bus_ena <= 0.
    - pready <= 1, pslverr <= 1, prdata <= 0.
    - Go to RESP.
  - A handshake in the same cycle the counter hits its limit wins; no error is flagged.
- RESP:
  - pready=1 for exactly one cycle, then pready <= 0, prdata <= 0, pslverr <= 0, counter <= 0, go to IDLE.
  - A new setup phase cannot occur in this cycle (it is the APB access-phase end), so no back-to-back overlap is handled.
- Latency:
  - Setup in cycle 0; bus_ena=1 in cycle 1.
  - Zero-wait bus (bus_ready=1 in cycle 1) gives pready=1 in cycle 2.
  - Each bus wait cycle adds one APB wait cycle.
- bus_addr, bus_wdata and bus_wstb hold stable from bus_ena rise until the handshake, and keep their last value afterwards.
- psel deasserted while in REQ is an APB protocol violation. The bus transaction still completes or times out; the response is discarded (pready not driven); FSM returns to IDLE.
- bus_ready while bus_ena=0 (e.g. a late response after timeout) is ignored.
- rst asserted mid-transaction drops bus_ena immediately.

Test Plan:
- Read paddr=0x0000_0010 with bus_ready=1 in the first bus_ena cycle and bus_rdata=0xDEADBEEF -> bus_wstb=0, bus_addr=0x10, pready in cycle 2, prdata=0xDEADBEEF, pslverr=0.
- Write paddr=0x24, pwdata=0x1234_5678, pstrb=0b0101, bus_ready after 3 wait cycles -> bus_wstb=0b0101, bus_wdata=0x12345678 stable throughout, pready in cycle 5, pslverr=0.
- Read with bus_slverr=1 and bus_rdata=0xFFFF_FFFF at handshake -> pready=1, pslverr=1, prdata=0xFFFFFFFF.
- Read with TIMEOUT_CYCLES=4 and bus_ready held 0 -> bus_ena high exactly 4 cycles, then pready=1, pslverr=1, prdata=0. A later bus_ready=1 pulse causes no APB activity.
- Write with pstrb=0 -> bus_ena never asserted; pready=1 in cycle 1, pslverr=0.
- rst pulsed while in REQ with bus_ena=1 -> bus_ena=0 and pready=0 immediately. The next read completes normally with correct prdata.
